// File: rtl/bcd_score_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_score_counter_if
// Bundles the request and status signals of the BCD score counter so that
// the counter and whatever drives it share one connection point.
//
// Signals (DIGITS BCD digits wide where noted, digit 0 in bits [3:0]):
//   start_value [4*DIGITS] value adopted while reset is held
//   load        [1]        request to load load_value
//   load_value  [4*DIGITS] BCD value for a load request
//   inc / dec   [1]        add / subtract step
//   step        [4]        single BCD digit amount
//   value       [4*DIGITS] registered BCD count
//   at_max      [1]        value equals the upper bound
//   at_min      [1]        value equals zero
//   hit_max     [1]        pulse, value just entered the upper bound
//   wrapped     [1]        pulse, last inc/dec crossed a bound
//   err         [1]        pulse, last request was rejected
//
// Modports: master drives requests, slave (the counter) drives status.
// ---------------------------------------------------------------------------
interface bcd_score_counter_if #(
   parameter int DIGITS = 2
);
   logic [4*DIGITS-1:0] start_value;
   logic                load;
   logic [4*DIGITS-1:0] load_value;
   logic                inc;
   logic                dec;
   logic [3:0]          step;
   logic [4*DIGITS-1:0] value;
   logic                at_max;
   logic                at_min;
   logic                hit_max;
   logic                wrapped;
   logic                err;

   modport master (
      output start_value, load, load_value, inc, dec, step,
      input  value, at_max, at_min, hit_max, wrapped, err
   );

   modport slave (
      input  start_value, load, load_value, inc, dec, step,
      output value, at_max, at_min, hit_max, wrapped, err
   );
endinterface

// File: rtl/bcd_score_counter.sv
// ---------------------------------------------------------------------------
// bcd_score_counter
// Up/down BCD counter bounded to 0..MAX_VALUE. Out-of-range results either
// clamp to the bound (WRAP = 0) or wrap modulo MAX_VALUE+1 (WRAP = 1).
// Priority each cycle: rst > load > (inc and dec) > inc > dec > hold.
//
// Parameters:
//   DIGITS    number of BCD digits (1..4); must match the interface instance
//   MAX_VALUE upper bound as a decimal integer (1..10^DIGITS-1)
//   WRAP      0 = saturate, 1 = wrap
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; loads start_value (or 0 if invalid)
//   bus  slave side of bcd_score_counter_if (requests in, status out)
// ---------------------------------------------------------------------------
module bcd_score_counter #(
   parameter int DIGITS    = 2,
   parameter int MAX_VALUE = 21,
   parameter int WRAP      = 0
) (
   input  logic              clk,
   input  logic              rst,
   bcd_score_counter_if.slave bus
);

   localparam int W       = 4 * DIGITS;
   localparam int MODULUS = MAX_VALUE + 1;

   // Decimal value of a BCD word, most significant digit first.
   function automatic int bcd_to_int(input logic [W-1:0] b);
      int acc;
      acc = 0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         acc = acc * 10 + int'(b[4*d +: 4]);
      end
      return acc;
   endfunction

   // BCD encoding of a non-negative integer below 10^DIGITS.
   function automatic logic [W-1:0] int_to_bcd(input int n);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = n;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // True when every nibble is a legal decimal digit.
   function automatic logic is_bcd(input logic [W-1:0] b);
      logic ok;
      ok = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (b[4*d +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   localparam logic [W-1:0] MAX_BCD = int_to_bcd(MAX_VALUE);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;
   logic [W-1:0] reset_value;
   logic         at_max_q;
   logic         at_min_q;
   logic         hit_max_q;
   logic         wrapped_q;
   logic         err_q;
   logic         wrapped_d;
   logic         err_d;
   int           cur_int;
   int           step_int;
   int           sum_int;
   int           diff_int;

   // The digit-wise carry/borrow arithmetic is carried out on the decimal
   // magnitude of the count, which keeps every resulting digit in 0..9 and
   // makes the wrap-around a plain modulo even when MAX_VALUE is smaller
   // than a single step (so the result may need to go round more than once).
   assign cur_int  = bcd_to_int(value_q);
   assign step_int = int'(bus.step);
   assign sum_int  = cur_int + step_int;
   assign diff_int = cur_int - step_int;

   // Invalid or out-of-range start values fall back to zero.
   assign reset_value = (is_bcd(bus.start_value) && (bus.start_value <= MAX_BCD))
                        ? bus.start_value : '0;

   // Next-value and pulse selection in priority order. BCD words compare
   // correctly as plain binary once they are known to be valid BCD.
   always_comb begin
      value_d   = value_q;
      wrapped_d = 1'b0;
      err_d     = 1'b0;
      if (bus.load) begin
         if (is_bcd(bus.load_value) && (bus.load_value <= MAX_BCD)) begin
            value_d = bus.load_value;
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.inc && bus.dec) begin
         value_d = value_q;
      end else if (bus.inc || bus.dec) begin
         if (bus.step > 4'd9) begin
            err_d = 1'b1;
         end else if (bus.step != 4'd0) begin
            if (bus.inc) begin
               if (sum_int > MAX_VALUE) begin
                  wrapped_d = 1'b1;
                  value_d   = (WRAP != 0) ? int_to_bcd(sum_int % MODULUS) : MAX_BCD;
               end else begin
                  value_d = int_to_bcd(sum_int);
               end
            end else begin
               if (diff_int < 0) begin
                  // Biasing by ten moduli keeps the dividend positive since
                  // the shortfall is at most nine.
                  wrapped_d = 1'b1;
                  value_d   = (WRAP != 0)
                              ? int_to_bcd((diff_int + 10 * MODULUS) % MODULUS)
                              : '0;
               end else begin
                  value_d = int_to_bcd(diff_int);
               end
            end
         end
      end
   end

   // State and status registers. hit_max fires only when the bound is
   // entered from a different value, so sitting at the bound is silent.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q   <= reset_value;
         at_max_q  <= (reset_value == MAX_BCD);
         at_min_q  <= (reset_value == '0);
         hit_max_q <= 1'b0;
         wrapped_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         value_q   <= value_d;
         at_max_q  <= (value_d == MAX_BCD);
         at_min_q  <= (value_d == '0);
         hit_max_q <= (value_d == MAX_BCD) && (value_q != MAX_BCD);
         wrapped_q <= wrapped_d;
         err_q     <= err_d;
      end
   end

   assign bus.value   = value_q;
   assign bus.at_max  = at_max_q;
   assign bus.at_min  = at_min_q;
   assign bus.hit_max = hit_max_q;
   assign bus.wrapped = wrapped_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_score_counter
// Drives a saturating and a wrapping counter (both DIGITS=2, MAX_VALUE=21)
// with identical requests and compares every output after every edge with
// a decimal reference model of the counter's rules.
// ---------------------------------------------------------------------------
module tb_bcd_score_counter;

   localparam int DIGITS    = 2;
   localparam int MAX_VALUE = 21;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: index 0 is the saturating unit, 1 the wrapping one.
   int   model_val [2];

   bcd_score_counter_if #(.DIGITS(DIGITS)) sat_bus ();
   bcd_score_counter_if #(.DIGITS(DIGITS)) wrap_bus ();

   bcd_score_counter #(.DIGITS(DIGITS), .MAX_VALUE(MAX_VALUE), .WRAP(0)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sat_bus)
   );

   bcd_score_counter #(.DIGITS(DIGITS), .MAX_VALUE(MAX_VALUE), .WRAP(1)) dut_wrap (
      .clk (clk),
      .rst (rst),
      .bus (wrap_bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts and reports any difference.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int n);
      logic [7:0] r;
      r[7:4] = 4'(n / 10);
      r[3:0] = 4'(n % 10);
      return r;
   endfunction

   // Decimal interpretation of a two-digit BCD word; ok is low on bad digits.
   function automatic void from_bcd(input logic [7:0] b, output bit ok, output int n);
      ok = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
      n  = int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   // Counter behaviour expressed as plain decimal arithmetic.
   function automatic void model_next(input bit wrap_mode, input int cur, input bit ld,
                                      input logic [7:0] lv, input bit i, input bit d,
                                      input int st, output int nxt, output bit wr,
                                      output bit er);
      bit ok;
      int lv_int;
      int raw;
      nxt = cur;
      wr  = 1'b0;
      er  = 1'b0;
      raw = 0;
      if (ld) begin
         from_bcd(lv, ok, lv_int);
         if (ok && lv_int <= MAX_VALUE) nxt = lv_int;
         else er = 1'b1;
      end else if (i && d) begin
         nxt = cur;
      end else if (i || d) begin
         if (st > 9) begin
            er = 1'b1;
         end else if (st != 0) begin
            raw = i ? cur + st : cur - st;
            if (raw > MAX_VALUE || raw < 0) begin
               wr = 1'b1;
               if (wrap_mode) nxt = ((raw % (MAX_VALUE + 1)) + (MAX_VALUE + 1)) % (MAX_VALUE + 1);
               else           nxt = (raw > MAX_VALUE) ? MAX_VALUE : 0;
            end else begin
               nxt = raw;
            end
         end
      end
   endfunction

   // Drives one cycle of requests to both units, advances the model, waits
   // one edge and compares every output of both units.
   task automatic applyStimulus(input string tag, input logic r, input logic [7:0] sv,
                                input logic ld, input logic [7:0] lv, input logic i,
                                input logic d, input logic [3:0] st);
      int exp_val [2];
      bit exp_hit [2];
      bit exp_wr  [2];
      bit exp_er  [2];
      int obs_val [2];
      bit obs_max [2];
      bit obs_min [2];
      bit obs_hit [2];
      bit obs_wr  [2];
      bit obs_er  [2];
      bit ok;
      int sv_int;
      string nm;

      rst = r;
      sat_bus.start_value  = sv;  wrap_bus.start_value = sv;
      sat_bus.load         = ld;  wrap_bus.load        = ld;
      sat_bus.load_value   = lv;  wrap_bus.load_value  = lv;
      sat_bus.inc          = i;   wrap_bus.inc         = i;
      sat_bus.dec          = d;   wrap_bus.dec         = d;
      sat_bus.step         = st;  wrap_bus.step        = st;

      for (int k = 0; k < 2; k++) begin
         if (r) begin
            from_bcd(sv, ok, sv_int);
            exp_val[k] = (ok && sv_int <= MAX_VALUE) ? sv_int : 0;
            exp_wr[k]  = 1'b0;
            exp_er[k]  = 1'b0;
            exp_hit[k] = 1'b0;
         end else begin
            model_next(k == 1, model_val[k], ld, lv, i, d, int'(st),
                       exp_val[k], exp_wr[k], exp_er[k]);
            exp_hit[k] = (exp_val[k] == MAX_VALUE) && (model_val[k] != MAX_VALUE);
         end
         model_val[k] = exp_val[k];
      end

      @(posedge clk);
      #1;
      obs_val[0] = int'(sat_bus.value);   obs_val[1] = int'(wrap_bus.value);
      obs_max[0] = sat_bus.at_max;        obs_max[1] = wrap_bus.at_max;
      obs_min[0] = sat_bus.at_min;        obs_min[1] = wrap_bus.at_min;
      obs_hit[0] = sat_bus.hit_max;       obs_hit[1] = wrap_bus.hit_max;
      obs_wr[0]  = sat_bus.wrapped;       obs_wr[1]  = wrap_bus.wrapped;
      obs_er[0]  = sat_bus.err;           obs_er[1]  = wrap_bus.err;

      for (int k = 0; k < 2; k++) begin
         nm = (k == 0) ? "sat" : "wrap";
         checkOutput($sformatf("%s/%s value", tag, nm), obs_val[k], int'(to_bcd(exp_val[k])));
         checkOutput($sformatf("%s/%s at_max", tag, nm), int'(obs_max[k]), int'(exp_val[k] == MAX_VALUE));
         checkOutput($sformatf("%s/%s at_min", tag, nm), int'(obs_min[k]), int'(exp_val[k] == 0));
         checkOutput($sformatf("%s/%s hit_max", tag, nm), int'(obs_hit[k]), int'(exp_hit[k]));
         checkOutput($sformatf("%s/%s wrapped", tag, nm), int'(obs_wr[k]), int'(exp_wr[k]));
         checkOutput($sformatf("%s/%s err", tag, nm), int'(obs_er[k]), int'(exp_er[k]));
      end
   endtask

   initial begin
      logic       r;
      logic [7:0] sv;
      logic       ld;
      logic [7:0] lv;
      logic       i;
      logic       d;
      logic [3:0] st;

      model_val[0] = 0;
      model_val[1] = 0;
      rst = 1'b1;
      sat_bus.start_value = '0;  wrap_bus.start_value = '0;
      sat_bus.load = 1'b0;       wrap_bus.load = 1'b0;
      sat_bus.load_value = '0;   wrap_bus.load_value = '0;
      sat_bus.inc = 1'b0;        wrap_bus.inc = 1'b0;
      sat_bus.dec = 1'b0;        wrap_bus.dec = 1'b0;
      sat_bus.step = '0;         wrap_bus.step = '0;
      @(negedge clk);

      // Reset to 19 then count up into and past the bound.
      applyStimulus("rst19",  1, 8'h19, 0, 8'h00, 0, 0, 4'd1);
      checkOutput("rst19 const value", int'(sat_bus.value), 'h19);
      applyStimulus("inc1_a", 0, 8'h19, 0, 8'h00, 1, 0, 4'd1);
      applyStimulus("inc1_b", 0, 8'h19, 0, 8'h00, 1, 0, 4'd1);
      checkOutput("inc1_b const hit_max", int'(sat_bus.hit_max), 1);
      applyStimulus("inc1_c", 0, 8'h19, 0, 8'h00, 1, 0, 4'd1);
      checkOutput("inc1_c const sat value", int'(sat_bus.value), 'h21);
      checkOutput("inc1_c const sat wrapped", int'(sat_bus.wrapped), 1);

      // Digit carry.
      applyStimulus("ld09",   0, 8'h00, 1, 8'h09, 0, 0, 4'd0);
      applyStimulus("carry",  0, 8'h00, 0, 8'h00, 1, 0, 4'd3);
      checkOutput("carry const value", int'(sat_bus.value), 'h12);

      // Crossing the upper bound then the lower bound.
      applyStimulus("ld20",   0, 8'h00, 1, 8'h20, 0, 0, 4'd0);
      applyStimulus("inc5",   0, 8'h00, 0, 8'h00, 1, 0, 4'd5);
      checkOutput("inc5 const wrap value", int'(wrap_bus.value), 'h03);
      applyStimulus("dec4",   0, 8'h00, 0, 8'h00, 0, 1, 4'd4);
      checkOutput("dec4 const wrap value", int'(wrap_bus.value), 'h21);
      checkOutput("dec4 const wrap hit_max", int'(wrap_bus.hit_max), 1);
      applyStimulus("ld02",   0, 8'h00, 1, 8'h02, 0, 0, 4'd0);
      applyStimulus("dec7",   0, 8'h00, 0, 8'h00, 0, 1, 4'd7);
      checkOutput("dec7 const sat value", int'(sat_bus.value), 'h00);

      // Rejected loads, load beating inc, and the holding cases.
      applyStimulus("ld1A",   0, 8'h00, 1, 8'h1A, 0, 0, 4'd0);
      applyStimulus("ld22",   0, 8'h00, 1, 8'h22, 0, 0, 4'd0);
      applyStimulus("ld21inc",0, 8'h00, 1, 8'h21, 1, 0, 4'd1);
      applyStimulus("step12", 0, 8'h00, 0, 8'h00, 0, 1, 4'd12);
      applyStimulus("incdec", 0, 8'h00, 0, 8'h00, 1, 1, 4'd3);
      applyStimulus("step0",  0, 8'h00, 0, 8'h00, 1, 0, 4'd0);

      // Reset with an invalid start value concurrent with a load.
      applyStimulus("rst3F",  1, 8'h3F, 1, 8'h05, 1, 0, 4'd2);
      checkOutput("rst3F const value", int'(sat_bus.value), 'h00);
      applyStimulus("resume", 0, 8'h3F, 0, 8'h00, 1, 0, 4'd2);

      // Randomized traffic, biased toward legal values.
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 39) == 0);
         sv = ($urandom_range(0, 1) == 1) ? to_bcd(int'($urandom_range(0, 25))) : 8'($urandom);
         ld = ($urandom_range(0, 7) == 0);
         lv = ($urandom_range(0, 3) != 0) ? to_bcd(int'($urandom_range(0, 25))) : 8'($urandom);
         i  = 1'($urandom_range(0, 1));
         d  = 1'($urandom_range(0, 1));
         st = 4'($urandom_range(0, 11));
         applyStimulus($sformatf("rnd%0d", n), r, sv, ld, lv, i, d, st);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
